franco_mezzarapa: RTL and testbench
===================================

Name: franco_mezzarapa

Overview:
- Tiny Tapeout top-level serial XOR cipher.
- Shifts in an 8-bit key and a 64-bit message one bit per clock on ui_in[0].
- Computes ciphertext as each message bit XOR the repeating key bit (message bit i XOR key bit i mod 8).
- Shifts the 64-bit ciphertext back out on uo_out[0] with a valid flag, and raises a status flag during encryption.

Parameters:
- KEY_W, 8, key width in bits (fixed for this tapeout)
- MSG_W, 64, message/ciphertext width in bits (fixed)

Ports:
- clk  in  1  system clock, rising-edge active
- rst_n  in  1  reset, asynchronous, active-low
- ena  in  1  design enable; when 0 all registers hold their value
- ui_in  in  8  [0] serial data, [1] load_key, [2] load_msg, [7:3] ignored
- uo_out  out  8  [0] serial ciphertext, [1] out_valid, [2] encrypting, [7:3] constant 0
- uio_in  in  8  unused, ignored
- uio_out  out  8  constant 0
- uio_oe  out  8  constant 0 (all bidirectional pins are inputs)

Behaviour:
- Reset (rst_n=0, asynchronous):
  - key=0, msg=0, ct=0, msg_cnt=0, out_cnt=0.
  - State=IDLE; all uo_out bits=0.
- All sequential logic updates on the rising edge of clk, and only when ena=1.
- States: IDLE, ENCRYPT, OUTPUT.
- IDLE:
  - If load_key=1: key <= {ui_in[0], key[7:1]}. Bits are LSB first, so after 8 edges key[i] = i-th bit sent. More than 8 bits keeps the last 8.
  - Else if load_msg=1: msg <= {ui_in[0], msg[63:1]} (LSB first). msg_cnt increments, saturating at 64. More than 64 bits keeps the last 64.
  - load_key has priority if both load signals are high.
  - A registered copy of load_msg detects its falling edge (previous 1, current 0, load_key=0).
  - On the falling edge with msg_cnt=64: go to ENCRYPT.
  - On the falling edge with msg_cnt<64: clear msg_cnt and stay in IDLE (partial message discarded).
- ENCRYPT (exactly 1 cycle):
  - ct[i] <= msg[i] ^ key[i%8] for i=0..63.
  - uo_out[2]=1 during this cycle.
  - out_cnt <= 0, msg_cnt <= 0.
  - Next state is OUTPUT.
- OUTPUT (exactly 64 cycles):
  - uo_out[1]=1 and uo_out[0]=ct[63-out_cnt], so ciphertext goes out MSB first, one bit per clock.
  - out_cnt increments each cycle. After the cycle with out_cnt=63, go to IDLE with uo_out[1]=0.
- Load signals are ignored while in ENCRYPT or OUTPUT; no abort and no shifting.
- Key is retained across messages and can be reloaded in IDLE at any time.
- All outputs are registered or decoded from state; no combinational path from ui_in to uo_out.
- Reset mid-operation returns everything to its reset values immediately.
- ena=0 mid-operation freezes state and counters; operation resumes when ena returns to 1.

Test Plan:
- Reset: rst_n=0 -> uo_out=0x00, uio_out=0x00, uio_oe=0x00; after release, state is IDLE and uo_out[1]=0.
- Nominal encryption:
  - Stimulus: load key 0xA5 LSB first (8 clocks, load_key=1), then message 0xA3B1F9D2E7C6A594 LSB first (64 clocks, load_msg=1), then drop load_msg.
  - Response: uo_out[2] pulses for 1 cycle.
  - Then uo_out[1] stays high for exactly 64 cycles.
  - The bits on uo_out[0] assemble MSB first into 0x06145C7742630031.
- Key reuse: without reloading the key, send message 0x0000000000000000 -> ciphertext 0xA5A5A5A5A5A5A5A5.
- Short message: send only 10 bits, then drop load_msg -> no uo_out[2] pulse and no uo_out[1]. A following full 64-bit load encrypts correctly.
- Priority and ignore rules:
  - With load_key and load_msg both high, only the key shifts.
  - Toggling load_key during OUTPUT leaves the key unchanged and the output stream uncorrupted.
- Enable and reset interference:
  - ena=0 for 5 cycles mid-OUTPUT -> the stream pauses and resumes with no lost or duplicated bits.
  - rst_n=0 mid-OUTPUT -> uo_out=0 immediately and state is IDLE.

Source files
------------

// File: rtl/franco_mezzarapa.sv
// franco_mezzarapa: serial XOR cipher for a Tiny Tapeout tile.
// An 8-bit key and a 64-bit message are shifted in LSB first on ui_in[0].
// Each message bit is XORed with key bit (i mod 8), and the 64-bit
// ciphertext is shifted back out MSB first on uo_out[0].
//
// Pin map:
//   ui_in[0]  serial data      uo_out[0] serial ciphertext
//   ui_in[1]  load_key         uo_out[1] out_valid (state OUTPUT)
//   ui_in[2]  load_msg         uo_out[2] encrypting (state ENCRYPT)
//
// Handshake: there is no backpressure. A ciphertext bit on uo_out[0] is
// valid in every enabled cycle where uo_out[1]=1, and a new bit appears
// after each enabled rising edge. While ena=0, every register holds, so
// the current bit and out_valid stay on the pins until ena returns.
//
// The FSM state is visible on uo_out[2:1]: 00 IDLE, 10 ENCRYPT, 01 OUTPUT.
module franco_mezzarapa #(
  parameter int KEY_W = 8,
  parameter int MSG_W = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int CNT_W = $clog2(MSG_W + 1);
  localparam int OUT_W = $clog2(MSG_W);
  localparam logic [CNT_W-1:0] MSG_FULL = CNT_W'(MSG_W);
  localparam logic [OUT_W-1:0] OUT_LAST = OUT_W'(MSG_W - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ENCRYPT = 2'd1,
    OUTPUT  = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [KEY_W-1:0] key;
  logic [MSG_W-1:0] msg;
  logic [MSG_W-1:0] ct;
  logic [CNT_W-1:0] msg_cnt;
  logic [OUT_W-1:0] out_cnt;
  logic             load_msg_q;

  logic serial_in;
  logic load_key;
  logic load_msg;
  logic msg_fall;
  logic unused_ok;

  assign serial_in = ui_in[0];
  assign load_key  = ui_in[1];
  assign load_msg  = ui_in[2];

  // End of a message burst; load_key masks it because key loading wins.
  assign msg_fall = load_msg_q & ~load_msg & ~load_key;

  // Pins this design never looks at.
  assign unused_ok = &{1'b0, uio_in, ui_in[7:3]};

  // State register; ena=0 freezes the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else if (ena) begin
      state <= state_next;
    end
  end

  // Next-state decode: a complete message starts one encrypt cycle, then
  // exactly MSG_W output cycles follow.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (msg_fall && (msg_cnt == MSG_FULL)) begin
          state_next = ENCRYPT;
        end
      end
      ENCRYPT: state_next = OUTPUT;
      OUTPUT: begin
        if (out_cnt == OUT_LAST) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: key/message shifters, ciphertext register and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key        <= '0;
      msg        <= '0;
      ct         <= '0;
      msg_cnt    <= '0;
      out_cnt    <= '0;
      load_msg_q <= 1'b0;
    end else if (ena) begin
      load_msg_q <= load_msg;
      unique case (state)
        IDLE: begin
          if (load_key) begin
            key <= {serial_in, key[KEY_W-1:1]};
          end else if (load_msg) begin
            msg <= {serial_in, msg[MSG_W-1:1]};
            if (msg_cnt != MSG_FULL) begin
              msg_cnt <= msg_cnt + 1'b1;
            end
          end else if (msg_fall && (msg_cnt != MSG_FULL)) begin
            // Short burst: throw the partial count away.
            msg_cnt <= '0;
          end
        end
        ENCRYPT: begin
          // Replicating the key byte lines key bit (i mod 8) up with msg bit i.
          ct      <= msg ^ {(MSG_W / KEY_W){key}};
          out_cnt <= '0;
          msg_cnt <= '0;
        end
        OUTPUT: begin
          out_cnt <= out_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Outputs decode straight from registered state; ui_in never reaches uo_out.
  always_comb begin
    uo_out    = 8'h00;
    uo_out[2] = (state == ENCRYPT);
    uo_out[1] = (state == OUTPUT);
    uo_out[0] = (state == OUTPUT) & ct[OUT_LAST - out_cnt];
    uio_out   = 8'h00;
    uio_oe    = 8'h00;
  end

endmodule

// File: tb/tb_franco_mezzarapa.sv
// Bench for franco_mezzarapa: table of full key/message encryptions plus
// hand-written sequences for short messages, load priority, ignored loads,
// enable pause and reset during output.
module tb_franco_mezzarapa;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks = 0;
  int errors = 0;

  franco_mezzarapa dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  // Clock and reset.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit          reload_key;
    logic [7:0]  key;
    logic [63:0] msg;
    logic [63:0] exp_ct;
  } vec_t;

  vec_t vecs[5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Shift n bits of data, starting at bit 'from', LSB first, with the given load flags.
  task automatic drive_bits(input logic [63:0] data, input int from, input int n,
                            input logic lk, input logic lm);
    for (int i = 0; i < n; i++) begin
      ui_in = {5'b0, lm, lk, data[from + i]};
      tick();
    end
  endtask

  // Run from the cycle where load_msg drops until well past the output window.
  // Collects out_valid bits MSB first; optionally pauses ena for 5 cycles after
  // pause_at bits, and optionally toggles load_key while busy.
  task automatic capture(input logic [63:0] exp_ct, input int pause_at, input bit toggle_key,
                         output logic [63:0] got, output int enc_n, output int val_n);
    got   = '0;
    enc_n = 0;
    val_n = 0;
    for (int c = 0; c < 90; c++) begin
      tick();
      if (uo_out[2]) enc_n++;
      if (uo_out[1]) begin
        got = {got[62:0], uo_out[0]};
        val_n++;
      end
      if (toggle_key && (uo_out[2] || uo_out[1]))
        ui_in = {5'b0, 1'b0, 1'(c[0]), 1'($urandom_range(0, 1))};
      else
        ui_in = 8'h00;
      if (uo_out[1] && (val_n == pause_at)) begin
        ena = 1'b0;
        for (int p = 0; p < 5; p++) begin
          tick();
          check("pause_valid", 64'(uo_out[1]), 64'd1);
          check("pause_bit", 64'(uo_out[0]), 64'(exp_ct[64 - val_n]));
        end
        ena = 1'b1;
      end
    end
  endtask

  task automatic run_msg(input string name, input logic [63:0] msg, input logic [63:0] exp_ct,
                         input int pause_at, input bit toggle_key);
    logic [63:0] got;
    int enc_n;
    int val_n;
    drive_bits(msg, 0, 64, 1'b0, 1'b1);
    ui_in = 8'h00;
    capture(exp_ct, pause_at, toggle_key, got, enc_n, val_n);
    check({name, "_ct"}, got, exp_ct);
    check({name, "_enc_cycles"}, 64'(enc_n), 64'd1);
    check({name, "_valid_cycles"}, 64'(val_n), 64'd64);
  endtask

  initial begin
    logic [63:0] got;
    int enc_n;
    int val_n;

    vecs[0] = '{1'b1, 8'hA5, 64'hA3B1F9D2E7C6A594, 64'h06145C7742630031};
    vecs[1] = '{1'b0, 8'h00, 64'h0000000000000000, 64'hA5A5A5A5A5A5A5A5};
    vecs[2] = '{1'b1, 8'h3C, 64'hFFFFFFFFFFFFFFFF, 64'hC3C3C3C3C3C3C3C3};
    vecs[3] = '{1'b1, 8'h01, 64'h0123456789ABCDEF, 64'h0022446688AACCEE};
    vecs[4] = '{1'b1, 8'hFF, 64'h0F0F0F0F0F0F0F0F, 64'hF0F0F0F0F0F0F0F0};

    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    #23;
    check("reset_uo_out", 64'(uo_out), 64'h00);
    check("reset_uio_out", 64'(uio_out), 64'h00);
    check("reset_uio_oe", 64'(uio_oe), 64'h00);
    rst_n = 1'b1;
    tick();
    check("idle_after_reset", 64'(uo_out), 64'h00);

    // Table of complete encryptions.
    for (int v = 0; v < 5; v++) begin
      if (vecs[v].reload_key) drive_bits(64'(vecs[v].key), 0, 8, 1'b1, 1'b0);
      run_msg($sformatf("vec%0d", v), vecs[v].msg, vecs[v].exp_ct, -1, 1'b0);
    end

    // Short message is discarded; a full one afterwards still works (key 0xFF).
    drive_bits(64'h3FF, 0, 10, 1'b0, 1'b1);
    ui_in = 8'h00;
    capture(64'h0, -1, 1'b0, got, enc_n, val_n);
    check("short_enc_cycles", 64'(enc_n), 64'd0);
    check("short_valid_cycles", 64'(val_n), 64'd0);
    run_msg("after_short", 64'hA3B1F9D2E7C6A594, 64'h5C4E062D18395A6B, -1, 1'b0);

    // Both loads high mid-message: only the key shifts, message count unaffected.
    drive_bits(64'h0123456789ABCDEF, 0, 60, 1'b0, 1'b1);
    drive_bits(64'h5A, 0, 8, 1'b1, 1'b1);
    drive_bits(64'h0123456789ABCDEF, 60, 4, 1'b0, 1'b1);
    ui_in = 8'h00;
    capture(64'h0, -1, 1'b0, got, enc_n, val_n);
    check("prio_ct", got, 64'h5B791F3DD3F197B5);
    check("prio_enc_cycles", 64'(enc_n), 64'd1);
    check("prio_valid_cycles", 64'(val_n), 64'd64);

    // load_key toggling while busy is ignored; key 0x5A survives.
    run_msg("toggle", 64'hA3B1F9D2E7C6A594, 64'hF9EBA388BD9CFFCE, -1, 1'b1);
    run_msg("key_kept", 64'h0, 64'h5A5A5A5A5A5A5A5A, -1, 1'b0);

    // ena low for 5 cycles after 20 output bits.
    run_msg("pause", 64'h0123456789ABCDEF, 64'h5B791F3DD3F197B5, 20, 1'b0);

    // Reset in the middle of output.
    drive_bits(64'hA3B1F9D2E7C6A594, 0, 64, 1'b0, 1'b1);
    ui_in = 8'h00;
    for (int c = 0; c < 12; c++) tick();
    check("pre_reset_valid", 64'(uo_out[1]), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_reset_uo_out", 64'(uo_out), 64'h00);
    #1;
    rst_n = 1'b1;
    tick();
    check("post_reset_idle", 64'(uo_out), 64'h00);
    run_msg("post_reset_zero_key", 64'h0123456789ABCDEF, 64'h0123456789ABCDEF, -1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
